pc_sequencer: RTL and testbench

//  Program-flow controller for the 9-bit RISC core: owns the program counter and the run/halt FSM.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_sequencer_jump_lut.sv | 31 +++
 rtl/pc_sequencer.sv | 90 +++++++++
 tb/tb_pc_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types, widths, opcodes and default jump-target table for pc_sequencer
package pc_seq_pkg;

    localparam int PC_W_DEF   = 10;
    localparam int JPTR_W_DEF = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_BLT = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;

    // Entry i holds (i*37 + 9) mod 1024, so entry 3 is 120 and entry 0 is 9
    localparam logic [PC_W_DEF-1:0] JMP_LUT_INIT [2**JPTR_W_DEF] = '{
        10'd9,   10'd46,  10'd83,  10'd120, 10'd157, 10'd194, 10'd231, 10'd268,
        10'd305, 10'd342, 10'd379, 10'd416, 10'd453, 10'd490, 10'd527, 10'd564,
        10'd601, 10'd638, 10'd675, 10'd712, 10'd749, 10'd786, 10'd823, 10'd860,
        10'd897, 10'd934, 10'd971, 10'd1008, 10'd21, 10'd58,  10'd95,  10'd132
    };

endpackage

// File: rtl/pc_sequencer_jump_lut.sv
// jump_lut: jump-target table, combinational read; writable when PC_SEQ_LUT_WR_EN is defined
module jump_lut
    import pc_seq_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int JPTR_W = JPTR_W_DEF
) (
`ifdef PC_SEQ_LUT_WR_EN
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [JPTR_W-1:0] i_waddr,
    input  logic [PC_W-1:0]   i_wdata,
`endif
    input  logic [JPTR_W-1:0] i_raddr,
    output logic [PC_W-1:0]   o_rdata
);

`ifdef PC_SEQ_LUT_WR_EN
    logic [PC_W-1:0] r_mem [2**JPTR_W];

    // Synchronous write; a same-cycle read of the same entry still sees the old value
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
`else
    assign o_rdata = JMP_LUT_INIT[i_raddr];
`endif

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, branch flag and IDLE/RUN/DONE control; PC_SEQ_LUT_WR_EN adds LUT write ports
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int JPTR_W = JPTR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_stall,
    input  logic              i_jmp,
    input  logic              i_jcond,
    input  logic [JPTR_W-1:0] i_jptr,
    input  logic              i_cmp_vld,
    input  logic              i_cmp_true,
    input  logic              i_halt,
`ifdef PC_SEQ_LUT_WR_EN
    input  logic              i_lut_we,
    input  logic [JPTR_W-1:0] i_lut_addr,
    input  logic [PC_W-1:0]   i_lut_data,
`endif
    output logic [PC_W-1:0]   o_prog_ctr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_flag
);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_lut_q;
    logic            r_flag;
    logic            w_active;
    logic            w_taken;
    logic            w_end;

    jump_lut #(.PC_W(PC_W), .JPTR_W(JPTR_W)) u_lut (
`ifdef PC_SEQ_LUT_WR_EN
        .i_clk   (i_clk),
        .i_we    (i_lut_we && r_state == IDLE),
        .i_waddr (i_lut_addr),
        .i_wdata (i_lut_data),
`endif
        .i_raddr (i_jptr),
        .o_rdata (w_lut_q)
    );

    assign w_active = (r_state == RUN) && !i_stall;
    assign w_taken  = i_jmp && (!i_jcond || r_flag);
    // Program ends on halt, or when the PC would have to step past all-ones
    assign w_end    = i_halt || (!w_taken && (&r_pc));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (i_start ? RUN : IDLE) :
                      (r_state == RUN)  ? ((w_active && w_end) ? DONE : RUN) :
                      (r_state == DONE) ? (i_start ? DONE : IDLE) : IDLE;
    end

    // Status outputs decoded from the registered state only
    always_comb begin
        o_busy = (r_state == RUN);
        o_done = (r_state == DONE);
    end

    // PC and branch flag; halt beats a jump, conditional jumps consume the flag
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pc   <= '0;
            r_flag <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_pc   <= '0;
            r_flag <= 1'b0;
        end else if (w_active) begin
            if (!w_end) r_pc <= w_taken ? w_lut_q : r_pc + PC_W'(1);
            r_flag <= i_cmp_vld ? i_cmp_true : (i_jmp && i_jcond) ? 1'b0 : r_flag;
        end
    end

    assign o_prog_ctr = r_pc;
    assign o_flag     = r_flag;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus random stimulus checked against a behavioural model
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, start, stall, jmp, jcond, cmp_vld, cmp_true, halt;
    logic [4:0] jptr;
    logic [9:0] prog_ctr;
    logic       busy, done, flag;

    int checks = 0;
    int errors = 0;

    // Model: running/finished as two bits, PC as a plain integer
    int m_pc = 0;
    bit m_flag = 0, m_busy = 0, m_done = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_start    (start),
        .i_stall    (stall),
        .i_jmp      (jmp),
        .i_jcond    (jcond),
        .i_jptr     (jptr),
        .i_cmp_vld  (cmp_vld),
        .i_cmp_true (cmp_true),
        .i_halt     (halt),
        .o_prog_ctr (prog_ctr),
        .o_busy     (busy),
        .o_done     (done),
        .o_flag     (flag)
    );

    function automatic int lut(int i);
        return (i * 37 + 9) % 1024;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock from the current inputs, clock the DUT, compare
    task automatic step();
        bit taken, nflag;
        if (!reset_n) begin
            m_pc = 0; m_flag = 0; m_busy = 0; m_done = 0;
        end else if (m_done) begin
            if (!start) m_done = 0;
        end else if (!m_busy) begin
            if (start) begin m_busy = 1; m_pc = 0; m_flag = 0; end
        end else if (!stall) begin
            taken = jmp && (!jcond || m_flag);
            nflag = cmp_vld ? cmp_true : (jmp && jcond) ? 1'b0 : m_flag;
            if (halt) begin
                m_busy = 0; m_done = 1;
            end else if (taken) begin
                m_pc = lut(int'(jptr));
            end else if (m_pc == 1023) begin
                m_busy = 0; m_done = 1;
            end else begin
                m_pc = m_pc + 1;
            end
            m_flag = nflag;
        end
        @(posedge clk);
        #1;
        check("pc", 32'(prog_ctr), 32'(m_pc));
        check("flag", 32'(flag), 32'(m_flag));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic idle_ins();
        start = 0; stall = 0; jmp = 0; jcond = 0; jptr = '0;
        cmp_vld = 0; cmp_true = 0; halt = 0;
    endtask

    initial begin
        reset_n = 0;
        idle_ins();
        step(); step();
        check("rst_pc", 32'(prog_ctr), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1;

        // Start then plain counting
        start = 1; step();
        check("start_busy", 32'(busy), 1);
        check("start_pc", 32'(prog_ctr), 0);
        start = 0;
        repeat (5) step();
        check("count5", 32'(prog_ctr), 5);
        while (m_pc != 37) step();
        check("pc37", 32'(prog_ctr), 37);
        reset_n = 0; step(); step();
        check("midrun_rst_pc", 32'(prog_ctr), 0);
        check("midrun_rst_busy", 32'(busy), 0);
        check("midrun_rst_done", 32'(done), 0);
        reset_n = 1;

        // Compare true then conditional jump to lut[3]
        start = 1; step(); start = 0;
        cmp_vld = 1; cmp_true = 1; step();
        check("flag_set", 32'(flag), 1);
        cmp_vld = 0; jmp = 1; jcond = 1; jptr = 5'd3; step();
        check("cjmp_taken", 32'(prog_ctr), 120);
        check("cjmp_flag_clr", 32'(flag), 0);

        // Compare false: conditional falls through, unconditional always jumps
        jmp = 0; cmp_vld = 1; cmp_true = 0; step();
        cmp_vld = 0; jmp = 1; jcond = 1; step();
        check("cjmp_not_taken", 32'(prog_ctr), 122);
        jcond = 0; step();
        check("ujmp_flag0", 32'(prog_ctr), 120);
        jmp = 0; cmp_vld = 1; cmp_true = 1; step();
        cmp_vld = 0; jmp = 1; jcond = 0; step();
        check("ujmp_flag1", 32'(prog_ctr), 120);
        check("ujmp_keeps_flag", 32'(flag), 1);

        // Stall freezes a pending jump
        jptr = 5'd5; stall = 1;
        repeat (3) step();
        check("stall_hold", 32'(prog_ctr), 120);
        stall = 0; step();
        check("stall_release", 32'(prog_ctr), 194);

        // Halt at PC 9
        jptr = 5'd0; step();
        jmp = 0; halt = 1; step();
        check("halt_done", 32'(done), 1);
        check("halt_pc", 32'(prog_ctr), 9);
        halt = 0; start = 1; step();
        check("done_hold", 32'(done), 1);
        start = 0; step();
        check("back_idle", 32'(done), 0);

        // Run off the top of the address space
        start = 1; step(); start = 0;
        jmp = 1; jptr = 5'd27; step(); jmp = 0;
        while (m_pc != 1023 && m_busy) step();
        step();
        check("end_done", 32'(done), 1);
        check("end_no_wrap", 32'(prog_ctr), 1023);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n  = ($urandom_range(0, 199) != 0);
            start    = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            jmp      = ($urandom_range(0, 3) == 0);
            jcond    = $urandom_range(0, 1) != 0;
            jptr     = 5'($urandom_range(0, 31));
            cmp_vld  = ($urandom_range(0, 3) == 0);
            cmp_true = $urandom_range(0, 1) != 0;
            halt     = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
